chunked_addsub: RTL and testbench

Parametrised, multi-cycle adder/subtractor for wide operands. It processes WIDTH-bit operands CHUNK bits per clock through one CHUNK-bit ripple slice, carrying between chunks in a register. It generalises the team's fixed 4-bit ripple adder to arbitrary width, and adds subtract mode, a signed-overflow flag and valid/ready handshakes on both sides. It sits between a producer and a consumer that tolerate multi-cycle latency in exchange for a narrow carry chain.

---
 rtl/chunked_addsub.sv | 101 ++++++++++
 tb/tb_chunked_addsub.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock
// One CHUNK-bit ripple slice is reused NCH times with the carry held in a register.
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic [KW-1:0]    k;
    logic             cout_reg;
    logic             ovf_reg;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_carry;
    logic             slice_ovf;
    logic             accept;

    assign slice_a = a_reg[k*CHUNK +: CHUNK];
    assign slice_b = b_reg[k*CHUNK +: CHUNK];
    assign {slice_carry, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
    // Same-sign operands giving a different-sign result is equivalent to carry-in(MSB) ^ carry-out(MSB).
    assign slice_ovf = (slice_a[CHUNK-1] == slice_b[CHUNK-1]) && (slice_sum[CHUNK-1] != slice_a[CHUNK-1]);

    assign accept    = (state == IDLE) && in_valid;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (k == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            k        <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= cin ^ sub;
            k     <= '0;
        end else if (state == RUN) begin
            sum_reg[k*CHUNK +: CHUNK] <= slice_sum;
            carry <= slice_carry;
            k     <= k + 1'b1;
            if (k == LAST) begin
                cout_reg <= slice_carry;
                ovf_reg  <= slice_ovf;
            end
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// tb/tb_chunked_addsub.sv - directed vectors, corner sequences and random sweeps for chunked_addsub
module tb_chunked_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        in_ready, out_valid, cout, ovf;
    logic [31:0] sum;

    logic        s8_iv = 1'b0, s8_or = 1'b0, s8_cin = 1'b0, s8_sub = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        s8_ir, s8_ov, s8_co, s8_of;
    logic [7:0]  s8_sum;

    logic        s12_iv = 1'b0, s12_or = 1'b0, s12_cin = 1'b0, s12_sub = 1'b0;
    logic [11:0] s12_a = '0, s12_b = '0;
    logic        s12_ir, s12_ov, s12_co, s12_of;
    logic [11:0] s12_sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(s8_iv), .in_ready(s8_ir),
        .a(s8_a), .b(s8_b), .cin(s8_cin), .sub(s8_sub), .out_valid(s8_ov),
        .out_ready(s8_or), .sum(s8_sum), .cout(s8_co), .ovf(s8_of)
    );

    chunked_addsub #(.WIDTH(12), .CHUNK(3)) dut12 (
        .clk(clk), .rst(rst), .in_valid(s12_iv), .in_ready(s12_ir),
        .a(s12_a), .b(s12_b), .cin(s12_cin), .sub(s12_sub), .out_valid(s12_ov),
        .out_ready(s12_or), .sum(s12_sum), .cout(s12_co), .ovf(s12_of)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        longint s;
        bit     co;
        bit     ov;
    } exp_t;

    vec_t vecs[12];
    exp_t q8[$];
    exp_t q12[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Integer reference: unsigned result/borrow and signed range test, independent of chunking.
    function automatic exp_t ref_model(input int w, input longint ra, input longint rb,
                                       input bit rcin, input bit rsub);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint sa = (ra >= half) ? ra - (longint'(1) << w) : ra;
        longint sb = (rb >= half) ? rb - (longint'(1) << w) : rb;
        longint r;
        if (!rsub) begin
            e.s  = (ra + rb + longint'(rcin)) & mask;
            e.co = ((ra + rb + longint'(rcin)) > mask);
            r    = sa + sb + longint'(rcin);
        end else begin
            e.s  = (ra - rb - longint'(rcin)) & mask;
            e.co = (ra >= rb + longint'(rcin));
            r    = sa - sb - longint'(rcin);
        end
        e.ov = (r < -half) || (r > half - 1);
        return e;
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                         input logic tsub, output logic [31:0] rs, output logic rc,
                         output logic ro, output int lat);
        int w = 0;
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        // Scramble inputs after the accept edge; the result must not depend on them.
        in_valid = 1'b0; a = 32'hDEADBEEF; b = ~ta; cin = ~tcin; sub = ~tsub;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout; ro = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic sweep8();
        int   done = 0;
        int   cyc = 0;
        bit   acc = 1'b0;
        exp_t e;
        while (done < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!s8_iv || acc) begin
                s8_a = 8'($urandom); s8_b = 8'($urandom);
                s8_cin = 1'($urandom); s8_sub = 1'($urandom);
                s8_iv = ($urandom_range(0, 3) != 0);
            end
            s8_or = ($urandom_range(0, 2) != 0);
            #1;
            acc = s8_iv && s8_ir;
            if (acc) q8.push_back(ref_model(8, longint'(s8_a), longint'(s8_b), s8_cin, s8_sub));
            if (s8_ov && s8_or) begin
                if (q8.size() == 0) begin
                    chk("sw8_spurious", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("sw8_sum", longint'(s8_sum), e.s);
                    chk("sw8_cout", longint'(s8_co), longint'(e.co));
                    chk("sw8_ovf", longint'(s8_of), longint'(e.ov));
                    done++;
                end
            end
        end
        @(negedge clk);
        s8_iv = 1'b0; s8_or = 1'b0;
        chk("sw8_ops_done", done, 1000);
    endtask

    task automatic sweep12();
        int   done = 0;
        int   cyc = 0;
        bit   acc = 1'b0;
        exp_t e;
        while (done < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (!s12_iv || acc) begin
                s12_a = 12'($urandom); s12_b = 12'($urandom);
                s12_cin = 1'($urandom); s12_sub = 1'($urandom);
                s12_iv = ($urandom_range(0, 3) != 0);
            end
            s12_or = ($urandom_range(0, 2) != 0);
            #1;
            acc = s12_iv && s12_ir;
            if (acc) q12.push_back(ref_model(12, longint'(s12_a), longint'(s12_b), s12_cin, s12_sub));
            if (s12_ov && s12_or) begin
                if (q12.size() == 0) begin
                    chk("sw12_spurious", 1, 0);
                end else begin
                    e = q12.pop_front();
                    chk("sw12_sum", longint'(s12_sum), e.s);
                    chk("sw12_cout", longint'(s12_co), longint'(e.co));
                    chk("sw12_ovf", longint'(s12_of), longint'(e.ov));
                    done++;
                end
            end
        end
        @(negedge clk);
        s12_iv = 1'b0; s12_or = 1'b0;
        chk("sw12_ops_done", done, 1000);
    endtask

    initial begin
        logic [31:0] rs;
        logic        rc, ro;
        int          lat;
        int          seen;

        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[4]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};
        vecs[5]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[11] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

        #3;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_sum", longint'(sum), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_sum", i), longint'(rs), longint'(vecs[i].exp_sum));
            chk($sformatf("v%0d_cout", i), longint'(rc), longint'(vecs[i].exp_cout));
            chk($sformatf("v%0d_ovf", i), longint'(ro), longint'(vecs[i].exp_ovf));
        end

        // Backpressure: DONE holds while a second operand set waits on in_valid.
        @(negedge clk);
        a = 32'd100; b = 32'd23; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_first_latency", lat, 8);
        a = 32'h0F0F0F0F; b = 32'h01010101; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", i), longint'(out_valid), 1);
            chk($sformatf("bp_hold%0d_ready", i), longint'(in_ready), 0);
            chk($sformatf("bp_hold%0d_sum", i), longint'(sum), 123);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_after_hs_valid", longint'(out_valid), 0);
        chk("bp_after_hs_ready", longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_latency", lat, 8);
        chk("bp_second_sum", longint'(sum), 32'h0E0E0E0E);
        chk("bp_second_cout", longint'(cout), 1);
        chk("bp_second_ovf", longint'(ovf), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset while DONE holds a nonzero result.
        do_op(32'h0, 32'h0, 1'b0, 1'b0, rs, rc, ro, lat);
        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("async_pre_valid", longint'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_sum", longint'(sum), 0);
        chk("async_cout", longint'(cout), 0);
        chk("async_ovf", longint'(ovf), 0);
        chk("async_out_valid", longint'(out_valid), 0);
        chk("async_in_ready", longint'(in_ready), 1);
        #1 rst = 1'b0;

        // Reset three cycles into RUN: that operation must never complete.
        @(negedge clk);
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_in_ready", longint'(in_ready), 1);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrun_no_valid", seen, 0);
        do_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, rs, rc, ro, lat);
        chk("midrun_next_latency", lat, 8);
        chk("midrun_next_sum", longint'(rs), 32'h23456789);
        chk("midrun_next_cout", longint'(rc), 0);
        chk("midrun_next_ovf", longint'(ro), 0);

        fork
            sweep8();
            sweep12();
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
